// File: rtl/ls_sequencer_pkg.sv
// rtl/ls_sequencer_pkg.sv - opcodes, halt word, FSM encoding and offset sign-extension
package ls_sequencer_pkg;

  localparam logic [10:0] OP_LDUR   = 11'h7C2;
  localparam logic [10:0] OP_STUR   = 11'h7C0;
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [63:0] sext_dt(input logic [8:0] dt);
    return {{55{dt[8]}}, dt};
  endfunction

endpackage

// File: rtl/ls_sequencer_decoder.sv
// rtl/ls_sequencer_decoder.sv - combinational LEGv8 D-format LDUR/STUR decoder
module ls_sequencer_decoder
  import ls_sequencer_pkg::*;
(
  input  logic [31:0] word,
  output logic        is_ldur,
  output logic        is_stur,
  output logic        is_halt,
  output logic        is_illegal,
  output logic [4:0]  rn,
  output logic [4:0]  rt,
  output logic [63:0] din64
);

  // op2 field [11:10] carries no meaning for LDUR/STUR
  logic unused_op2;
  assign unused_op2 = ^word[11:10];

  assign is_ldur    = (word[31:21] == OP_LDUR);
  assign is_stur    = (word[31:21] == OP_STUR);
  assign is_halt    = (word == HALT_WORD);
  assign is_illegal = !(is_ldur || is_stur || is_halt);
  assign rn         = word[9:5];
  assign rt         = word[4:0];
  assign din64      = sext_dt(word[20:12]);

endmodule

// File: rtl/ls_sequencer.sv
// rtl/ls_sequencer.sv - fetch/decode FSM issuing one rf load/store command per instruction
module ls_sequencer
  import ls_sequencer_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               rf_enable,
  output logic               rf_load_store,
  output logic [4:0]         rf_a,
  output logic [4:0]         rf_b,
  output logic [4:0]         rf_w,
  output logic [63:0]        rf_din,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   instr_count
);

  state_t             state, state_nx;
  logic [IMEM_AW-1:0] pc;
  logic               is_ldur, is_stur, is_halt, is_illegal;
  logic [4:0]         rn, rt;
  logic [63:0]        din64;
  logic               in_exec, issue;

  ls_sequencer_decoder u_dec (
    .word       (imem_rdata),
    .is_ldur    (is_ldur),
    .is_stur    (is_stur),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .rn         (rn),
    .rt         (rt),
    .din64      (din64)
  );

  // abort on an EXEC cycle suppresses the command issued in that same cycle
  assign in_exec = (state == S_EXEC);
  assign issue   = in_exec && !abort && (is_ldur || is_stur);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      err         <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        pc          <= '0;
        err         <= 1'b0;
        instr_count <= '0;
      end
      if (in_exec && !abort && is_illegal) err <= 1'b1;
      if (issue) begin
        if (instr_count != '1) instr_count <= instr_count + CNT_W'(1);
        if (pc != '1) pc <= pc + IMEM_AW'(1);
      end
    end
  end

  always_comb begin
    state_nx      = state;
    rf_enable     = 1'b0;
    rf_load_store = 1'b0;
    rf_a          = '0;
    rf_b          = '0;
    rf_w          = '0;
    rf_din        = '0;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: state_nx = abort ? S_DONE : S_EXEC;
      S_EXEC: begin
        if (abort) begin
          state_nx = S_DONE;
        end else if (issue) begin
          rf_enable     = 1'b1;
          rf_load_store = is_ldur;
          rf_a          = is_stur ? rt : 5'd0;
          rf_w          = is_ldur ? rt : 5'd0;
          rf_b          = rn;
          rf_din        = din64;
          // the last word of the address space ends the run rather than wrapping
          state_nx      = (pc == '1) ? S_DONE : S_FETCH;
        end else if (is_halt || is_illegal) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign imem_addr = pc;
  assign busy      = (state == S_FETCH) || (state == S_EXEC);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_ls_sequencer.sv
// tb/tb_ls_sequencer.sv - scoreboard bench for ls_sequencer with imem and rf models
module tb_ls_sequencer;

  typedef struct packed {
    logic        ls;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  w;
    logic [63:0] din;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [1:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        rf_enable, rf_load_store, busy, done, err;
  logic [4:0]  rf_a, rf_b, rf_w;
  logic [63:0] rf_din;
  logic [1:0]  instr_count;

  always #5 clk = ~clk;

  ls_sequencer #(.IMEM_AW(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .rf_enable(rf_enable), .rf_load_store(rf_load_store),
    .rf_a(rf_a), .rf_b(rf_b), .rf_w(rf_w), .rf_din(rf_din),
    .busy(busy), .done(done), .err(err), .instr_count(instr_count)
  );

  logic [31:0] imem [4];
  logic [63:0] regs [32];
  logic [63:0] dmem [16];
  logic [63:0] ea;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pulse_log[$];
  cmd_t        cmd_q[$];
  logic [2:0]  done_q[$];
  cmd_t        mon_e;
  logic [2:0]  mon_d;

  always @(posedge clk) imem_rdata <= imem[imem_addr];

  // rf model: commits on the rf_enable edge
  assign ea = rf_din + regs[rf_b];
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rf_enable) begin
      if (rf_load_store) regs[rf_w] = dmem[ea[3:0]];
      else               dmem[ea[3:0]] = regs[rf_a];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rf_enable) begin
      pulse_log.push_back(cyc);
      if (cmd_q.size() == 0) begin
        chk("unexpected_rf_enable", 64'(rf_enable), 64'd0);
      end else begin
        mon_e = cmd_q.pop_front();
        chk("cmd_load_store", 64'(rf_load_store), 64'(mon_e.ls));
        chk("cmd_b", 64'(rf_b), 64'(mon_e.b));
        chk("cmd_din", rf_din, mon_e.din);
        if (mon_e.ls) chk("cmd_w", 64'(rf_w), 64'(mon_e.w));
        else          chk("cmd_a", 64'(rf_a), 64'(mon_e.a));
      end
    end
    if (rst_n && done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_d = done_q.pop_front();
        chk("done_err", 64'(err), 64'(mon_d[2]));
        chk("done_instr_count", 64'(instr_count), 64'(mon_d[1:0]));
      end
    end
  end

  task automatic load_prog(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    imem[0] = w0; imem[1] = w1; imem[2] = w2; imem[3] = w3;
  endtask

  task automatic push_cmd(input logic ls, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] w, input logic [63:0] din);
    cmd_t c;
    c.ls = ls; c.a = a; c.b = b; c.w = w; c.din = din;
    cmd_q.push_back(c);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 64'd0;
    for (int i = 0; i < 16; i++) dmem[i] = 64'd0;
    load_prog(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_rf_enable", 64'(rf_enable), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_instr_count", 64'(instr_count), 64'd0);
    chk("reset_imem_addr", 64'(imem_addr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // two stores back to back, then HALT
    load_prog(32'hF800_0002, 32'hF800_20C4, 32'h0, 32'h0);
    regs[2] = 64'h22; regs[4] = 64'h44; regs[6] = 64'd1;
    push_cmd(1'b0, 5'd2, 5'd0, 5'd0, 64'd0);
    push_cmd(1'b0, 5'd4, 5'd6, 5'd0, 64'd2);
    done_q.push_back({1'b0, 2'd2});
    pulse_log.delete();
    pulse_start();
    wait_done("t1");
    chk("t1_pulse_count", 64'(pulse_log.size()), 64'd2);
    if (pulse_log.size() == 2) chk("t1_pulse_spacing", 64'(pulse_log[1] - pulse_log[0]), 64'd2);
    chk("t1_mem0", dmem[0], 64'h22);
    chk("t1_mem3", dmem[3], 64'h44);

    // load X2,[X13,#3]
    load_prog(32'hF840_31A2, 32'h0, 32'h0, 32'h0);
    regs[13] = 64'd5; dmem[8] = 64'h1234_5678_9ABC_DEF0;
    push_cmd(1'b1, 5'd0, 5'd13, 5'd2, 64'd3);
    done_q.push_back({1'b0, 2'd1});
    pulse_start();
    wait_done("t2");
    chk("t2_reg2", regs[2], 64'h1234_5678_9ABC_DEF0);

    // negative offset: load X3,[X21,#-1]
    load_prog(32'hF85F_F2A3, 32'h0, 32'h0, 32'h0);
    regs[21] = 64'd4; dmem[3] = 64'hCAFE_F00D;
    push_cmd(1'b1, 5'd0, 5'd21, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    done_q.push_back({1'b0, 2'd1});
    pulse_start();
    wait_done("t3");
    chk("t3_reg3", regs[3], 64'hCAFE_F00D);

    // store then illegal word
    load_prog(32'hF800_0002, 32'h8B00_0000, 32'h0, 32'h0);
    push_cmd(1'b0, 5'd2, 5'd0, 5'd0, 64'd0);
    done_q.push_back({1'b1, 2'd1});
    pulse_start();
    wait_done("t4");
    chk("t4_err_sticky", 64'(err), 64'd1);

    // abort during EXEC of the second store
    load_prog(32'hF800_0002, 32'hF800_20C4, 32'h0, 32'h0);
    push_cmd(1'b0, 5'd2, 5'd0, 5'd0, 64'd0);
    done_q.push_back({1'b0, 2'd1});
    pulse_start();
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("t5_abort_rf_enable", 64'(rf_enable), 64'd0);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t5_abort_done", 64'(done), 64'd1);
    repeat (2) @(posedge clk); #1;

    // reset in FETCH
    pulse_start();
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_rf_enable", 64'(rf_enable), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_count", 64'(instr_count), 64'd0);
    @(negedge clk);
    chk("t5_rst_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // four stores with no HALT: pc stops at 3, count saturates, mid-run start ignored
    load_prog(32'hF800_0001, 32'hF800_1022, 32'hF800_2043, 32'hF800_3064);
    push_cmd(1'b0, 5'd1, 5'd0, 5'd0, 64'd0);
    push_cmd(1'b0, 5'd2, 5'd1, 5'd0, 64'd1);
    push_cmd(1'b0, 5'd3, 5'd2, 5'd0, 64'd2);
    push_cmd(1'b0, 5'd4, 5'd3, 5'd0, 64'd3);
    done_q.push_back({1'b0, 2'd3});
    pulse_start();
    repeat (2) @(posedge clk);
    #1 pulse_start();
    wait_done("t6");
    chk("t6_pc_no_wrap", 64'(imem_addr), 64'd3);
    @(negedge clk);
    chk("t6_idle_busy", 64'(busy), 64'd0);

    repeat (4) @(posedge clk);
    chk("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
    chk("done_queue_drained", 64'(done_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
